// File: rtl/fir_bit_serializer_pkg.sv
// fir_pkg: shared widths and types for the FIR serial transmitter.
package fir_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIV = 4;
    typedef logic [DEF_DATA_W-1:0] sample_t;
    typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/fir_bit_serializer_tick.sv
// bit_tick_gen: bit-period divider; tick marks the last clk cycle of each serial bit.
module bit_tick_gen
    import fir_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = en && cnt_q == LAST;
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fir_bit_serializer.sv
// fir_bit_serializer: double-buffered parallel-to-serial transmitter, MSB first, DIV clks per bit,
// frame_out marks each word's MSB.
module fir_bit_serializer
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV = DEF_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_out,
    output logic              frame_out,
    output logic              busy
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] TOP_BIT = BW'(DATA_W - 1);
    ser_state_t state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic hold_valid_q, hold_valid_d, ready_q, ready_d;
    logic bit_q, bit_d, frame_q, frame_d, busy_q, busy_d;
    logic tick, accept, word_end, load;

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == SHIFT),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    // ready is its own register so it stays low through reset and rises one edge after release
    always_comb begin
        accept = s_valid && ready_q;
        word_end = tick && bit_cnt_q == '0;
        load = hold_valid_q && (state_q == IDLE || word_end);
        hold_d = accept ? s_data : hold_q;
        hold_valid_d = accept || (hold_valid_q && !load);
        ready_d = !hold_valid_d;
        state_d = load ? SHIFT : word_end ? IDLE : state_q;
        shift_d = load ? hold_q : tick ? shift_q << 1 : shift_q;
        bit_cnt_d = load ? TOP_BIT : (tick && !word_end) ? bit_cnt_q - BW'(1) : bit_cnt_q;
        bit_d = load ? hold_q[DATA_W-1] : word_end ? 1'b0 : tick ? shift_q[DATA_W-2] : bit_q;
        frame_d = load ? 1'b1 : tick ? 1'b0 : frame_q;
        busy_d = state_d == SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q <= '0;
            hold_valid_q <= 1'b0;
            ready_q <= 1'b0;
            shift_q <= '0;
            bit_cnt_q <= '0;
            bit_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q <= ready_d;
            shift_q <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bit_q <= bit_d;
            frame_q <= frame_d;
            busy_q <= busy_d;
        end
    end

    assign s_ready = ready_q;
    assign bit_out = bit_q;
    assign frame_out = frame_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_fir_bit_serializer.sv
// tb_fir_bit_serializer: scoreboard bench for the serializer at DIV=4 (u0) and DIV=1 (u1).
module tb_fir_bit_serializer;
    import fir_pkg::*;
    logic clk, rst;
    sample_t s_data0, s_data1;
    logic s_valid0, s_valid1, s_ready0, s_ready1;
    logic bit0, bit1, frame0, frame1, busy0, busy1;
    int n_cmp = 0, n_err = 0, ncyc = 0;
    int cnt[2] = '{-1, -1};
    int words[2] = '{0, 0};
    int gap[2] = '{-1, -1};
    int last_end[2] = '{0, 0};
    sample_t cur[2];
    sample_t q0[$], q1[$];

    fir_bit_serializer #(.DATA_W(16), .DIV(4)) dut0 (
        .clk(clk), .rst(rst), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
        .bit_out(bit0), .frame_out(frame0), .busy(busy0)
    );
    fir_bit_serializer #(.DATA_W(16), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .bit_out(bit1), .frame_out(frame1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int u, input int div, input logic b, input logic f, input logic bz);
        if (rst) begin
            cnt[u] = -1;
            if (u == 0) q0.delete(); else q1.delete();
            return;
        end
        if (cnt[u] < 0 && f) begin
            if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("u%0d_unexpected_word", u), 1, 0);
                cur[u] = 'x;
            end else if (u == 0) cur[u] = q0.pop_front();
            else cur[u] = q1.pop_front();
            gap[u] = ncyc - last_end[u] - 1;
            cnt[u] = 0;
        end
        if (cnt[u] < 0) check($sformatf("u%0d_idle_bit", u), b, 0);
        else begin
            check($sformatf("u%0d_bit%0d", u, cnt[u]), b, cur[u][15 - cnt[u] / div]);
            check($sformatf("u%0d_frame%0d", u, cnt[u]), f, cnt[u] < div);
            check($sformatf("u%0d_busy%0d", u, cnt[u]), bz, 1);
            cnt[u]++;
            if (cnt[u] == 16 * div) begin
                cnt[u] = -1;
                last_end[u] = ncyc;
                words[u]++;
            end
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        mon(0, 4, bit0, frame0, busy0);
        mon(1, 1, bit1, frame1, busy1);
    end

    task automatic send(input int u, input sample_t w);
        int n = 0;
        if (u == 0) begin s_data0 = w; s_valid0 = 1'b1; end
        else begin s_data1 = w; s_valid1 = 1'b1; end
        while (!(u == 0 ? s_ready0 : s_ready1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("accept_timeout", 0, 1);
        @(posedge clk);
        if (u == 0) q0.push_back(w); else q1.push_back(w);
        #1;
    endtask

    task automatic wait_words(input int u, input int target);
        int n = 0;
        while (words[u] < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("words_timeout", words[u], target);
    endtask

    task automatic wait_cnt(input int u, input int c);
        int n = 0;
        while (cnt[u] != c && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("cnt_timeout", cnt[u], c);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready0"}, s_ready0, 0);
        check({tag, "_ready1"}, s_ready1, 0);
        check({tag, "_bit0"}, bit0, 0);
        check({tag, "_frame0"}, frame0, 0);
        check({tag, "_busy0"}, busy0, 0);
        check({tag, "_busy1"}, busy1, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #3 rst = 1'b1;
        #1 check_reset(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, s_ready0, 1);
        check({tag, "_ready1_after"}, s_ready1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        s_valid0 = 1'b0;
        s_valid1 = 1'b0;
        s_data0 = '0;
        s_data1 = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("por_ready0", s_ready0, 1);
        check("por_ready1", s_ready1, 1);
        // reset pulse while the first bit of a word is on the line
        @(negedge clk);
        send(0, 16'hA5C3);
        s_valid0 = 1'b0;
        wait_cnt(0, 2);
        check("t1_bit_before_rst", bit0, 1);
        pulse_reset("t1");
        // single word, latency and full bit pattern
        @(negedge clk);
        base = words[0];
        send(0, 16'hA5C3);
        s_valid0 = 1'b0;
        check("t2_frame_t0", frame0, 0);
        @(posedge clk);
        #1;
        check("t2_frame_t1", frame0, 1);
        check("t2_msb_t1", bit0, 1);
        check("t2_busy_t1", busy0, 1);
        wait_words(0, base + 1);
        @(posedge clk);
        #1;
        check("t2_busy_end", busy0, 0);
        check("t2_bit_end", bit0, 0);
        // back-to-back words with no gap
        @(negedge clk);
        base = words[0];
        send(0, 16'hFFFF);
        send(0, 16'h0001);
        s_valid0 = 1'b0;
        wait_words(0, base + 2);
        check("t3_gap", gap[0], 0);
        // valid held high across three words
        @(negedge clk);
        base = words[0];
        send(0, 16'h1234);
        send(0, 16'h5678);
        check("t4_ready_full", s_ready0, 0);
        send(0, 16'h9ABC);
        s_valid0 = 1'b0;
        wait_words(0, base + 3);
        check("t4_gap", gap[0], 0);
        check("t4_queue_empty", q0.size(), 0);
        // reset at bit 7 of 16'h8001, then a fresh word
        @(negedge clk);
        send(0, 16'h8001);
        s_valid0 = 1'b0;
        wait_cnt(0, 29);
        check("t5_busy_before_rst", busy0, 1);
        pulse_reset("t5");
        @(negedge clk);
        base = words[0];
        send(0, 16'h8001);
        s_valid0 = 1'b0;
        check("t5_frame_t0", frame0, 0);
        @(posedge clk);
        #1;
        check("t5_frame_t1", frame0, 1);
        check("t5_msb_t1", bit0, 1);
        wait_words(0, base + 1);
        // DIV=1 back-to-back
        @(negedge clk);
        base = words[1];
        send(1, 16'h0F0F);
        send(1, 16'hF0F0);
        s_valid1 = 1'b0;
        wait_words(1, base + 2);
        check("t6_gap", gap[1], 0);
        check("t6_queue_empty", q1.size(), 0);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
